mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of NUM_CORES cores a 3-cycle access to a shared synchronous RAM.
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);

    localparam int                   PTR_W    = $clog2(NUM_CORES);
    localparam logic [PTR_W:0]       NCORES_W = (PTR_W + 1)'(NUM_CORES);
    localparam logic [PTR_W-1:0]     LAST_IDX = PTR_W'(NUM_CORES - 1);
    localparam logic [NUM_CORES-1:0] ONE_HOT0 = NUM_CORES'(1);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      win_q, win_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [NUM_CORES-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;

    logic [PTR_W-1:0]      pick_start;
    logic [2*NUM_CORES-1:0] req_rot;
    logic [PTR_W-1:0]      pick_off;
    logic [PTR_W:0]        pick_sum;
    logic [PTR_W-1:0]      pick_idx;
    logic [NUM_CORES-1:0]  gnt;
    logic                  handshake;
    logic                  sel_we;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign pick_start = '0;
`else
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    assign pick_start = rr_ptr_q;
`endif

    // Rotate so the scan start sits at bit 0; the lowest set bit is then the winner's offset.
    assign req_rot = {core_req, core_req} >> pick_start;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pick_off = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req_rot[i]) pick_off = PTR_W'(i);
        end
        pick_sum = {1'b0, pick_start} + {1'b0, pick_off};
        pick_idx = (pick_sum >= NCORES_W) ? PTR_W'(pick_sum - NCORES_W) : pick_sum[PTR_W-1:0];
    end

    assign gnt       = (state_q == IDLE && |core_req) ? (ONE_HOT0 << pick_idx) : '0;
    assign handshake = |(core_req & gnt);

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick_idx == PTR_W'(i)) begin
                sel_we    = core_we[i];
                sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = core_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d     = ACCESS;
                    win_d       = pick_idx;
                    mem_req_d   = 1'b1;
                    mem_we_d    = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    rr_ptr_d    = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
`endif
                end
            end
            ACCESS:  state_d = CAPTURE;
            CAPTURE: begin
                // Writes complete with zero data so a stale read value never leaks out.
                rdata_d  = mem_we_q ? '0 : mem_rdata;
                rvalid_d = ONE_HOT0 << win_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            win_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign core_gnt    = gnt;
    assign core_rvalid = rvalid_q;
    assign core_rdata  = rdata_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences, and a
// randomized run against a transaction-timeline reference model.
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      core_req, core_we;
    logic [N*AW-1:0]   core_addr;
    logic [N*DW-1:0]   core_wdata;
    logic [N-1:0]      core_gnt, core_rvalid;
    logic [DW-1:0]     core_rdata;
    logic              mem_req, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;
    logic              busy;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after mem_req.
    logic [DW-1:0] ram [256] = '{default: 32'hC0DE_0000};
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_core(input int c, input logic r, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_req[c]            = r;
        core_we[c]             = we;
        core_addr[c*AW +: AW]  = a;
        core_wdata[c*DW +: DW] = d;
    endtask

    task automatic do_reset();
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    // Reference arbitration: first requester scanning from ptr, modulo N.
    function automatic int pick(input logic [N-1:0] req, input int ptr);
        int start;
`ifdef MEM_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = ptr;
`endif
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Timeline model: a handshake in cycle h gives mem_req at h+1, busy at h+1..h+2,
    // rvalid and new rdata at h+3, and arbitration resumes at h+3.
    logic [DW-1:0] model_ram [256] = '{default: 32'hC0DE_0000};
    int            cyc, hs_cyc, hs_w, m_ptr, granted_w;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_result, m_rdata;

    task automatic model_reset();
        cyc = 0; hs_cyc = -100; hs_w = 0; m_ptr = 0; granted_w = -1;
        m_we = 1'b0; m_addr = '0; m_wdata = '0; m_result = '0; m_rdata = '0;
    endtask

    task automatic model_cycle();
        logic [N-1:0] eg, ev;
        int  w;
        bit  idle;
        if (cyc == hs_cyc + 3) m_rdata = m_result;
        idle = (cyc >= hs_cyc + 3);
        ev   = (cyc == hs_cyc + 3) ? onehot(hs_w) : '0;
        w    = pick(core_req, m_ptr);
        eg   = (idle && w >= 0) ? onehot(w) : '0;
        check("rnd gnt",       core_gnt,    eg);
        check("rnd rvalid",    core_rvalid, ev);
        check("rnd rdata",     core_rdata,  m_rdata);
        check("rnd mem_req",   mem_req,     (cyc == hs_cyc + 1) ? 1'b1 : 1'b0);
        check("rnd mem_we",    mem_we,      m_we);
        check("rnd mem_addr",  mem_addr,    m_addr);
        check("rnd mem_wdata", mem_wdata,   m_wdata);
        check("rnd busy",      busy,        (cyc == hs_cyc + 1 || cyc == hs_cyc + 2) ? 1'b1 : 1'b0);
        granted_w = -1;
        if (idle && w >= 0) begin
            hs_cyc    = cyc;
            hs_w      = w;
            granted_w = w;
            m_ptr     = (w + 1) % N;
            m_we      = core_we[w];
            m_addr    = core_addr[w*AW +: AW];
            m_wdata   = core_wdata[w*DW +: DW];
            m_result  = m_we ? '0 : model_ram[m_addr[9:2]];
            if (m_we) model_ram[m_addr[9:2]] = m_wdata;
        end
        cyc++;
    endtask

    typedef struct {
        int           core;
        logic         we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [N-1:0] exp_gnt;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];
    int   order [5];

    initial begin
        vecs[0] = '{core: 0, we: 1'b1, addr: 32'h40,  wdata: 32'hDEAD_BEEF, exp_gnt: 4'b0001, exp_rdata: 32'h0};
        vecs[1] = '{core: 2, we: 1'b0, addr: 32'h40,  wdata: 32'h0,         exp_gnt: 4'b0100, exp_rdata: 32'hDEAD_BEEF};
        vecs[2] = '{core: 1, we: 1'b1, addr: 32'h100, wdata: 32'h1234_5678, exp_gnt: 4'b0010, exp_rdata: 32'h0};
        vecs[3] = '{core: 1, we: 1'b0, addr: 32'h100, wdata: 32'h0,         exp_gnt: 4'b0010, exp_rdata: 32'h1234_5678};
        vecs[4] = '{core: 3, we: 1'b0, addr: 32'h200, wdata: 32'h0,         exp_gnt: 4'b1000, exp_rdata: 32'hC0DE_0000};
        vecs[5] = '{core: 3, we: 1'b1, addr: 32'h3FC, wdata: 32'hA5A5_5A5A, exp_gnt: 4'b1000, exp_rdata: 32'h0};
        vecs[6] = '{core: 0, we: 1'b0, addr: 32'h3FC, wdata: 32'h0,         exp_gnt: 4'b0001, exp_rdata: 32'hA5A5_5A5A};
`ifdef MEM_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif

        rst_n = 1'b1;
        do_reset();

        // Reset state
        #1;
        check("rst gnt",       core_gnt,    '0);
        check("rst rvalid",    core_rvalid, '0);
        check("rst rdata",     core_rdata,  '0);
        check("rst mem_req",   mem_req,     1'b0);
        check("rst mem_we",    mem_we,      1'b0);
        check("rst mem_addr",  mem_addr,    '0);
        check("rst mem_wdata", mem_wdata,   '0);
        check("rst busy",      busy,        1'b0);

        // Single-transaction vectors
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            set_core(vecs[t].core, 1'b1, vecs[t].we, vecs[t].addr, vecs[t].wdata);
            #1 check("tbl gnt", core_gnt, vecs[t].exp_gnt);
            @(negedge clk);
            core_req = '0;
            #1;
            check("tbl mem_req",   mem_req,   1'b1);
            check("tbl mem_we",    mem_we,    vecs[t].we);
            check("tbl mem_addr",  mem_addr,  vecs[t].addr);
            check("tbl mem_wdata", mem_wdata, vecs[t].wdata);
            check("tbl busy",      busy,      1'b1);
            @(negedge clk); #1;
            check("tbl mem_req off", mem_req,     1'b0);
            check("tbl rvalid early", core_rvalid, '0);
            @(negedge clk); #1;
            check("tbl rvalid", core_rvalid, vecs[t].exp_gnt);
            check("tbl rdata",  core_rdata,  vecs[t].exp_rdata);
            check("tbl idle",   busy,        1'b0);
            if (vecs[t].we) model_ram[vecs[t].addr[9:2]] = vecs[t].wdata;
        end
        @(negedge clk); #1 check("tbl rvalid pulse", core_rvalid, '0);

        // All cores request continuously from reset: one grant every 3 cycles
        do_reset();
        for (int c = 0; c < N; c++) set_core(c, 1'b1, 1'b0, AW'(c * 16), '0);
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check("rr gnt", core_gnt, (k % 3 == 0) ? onehot(order[k / 3]) : '0);
            if (k > 0) check("rr rvalid", core_rvalid, (k % 3 == 0) ? onehot(order[k / 3 - 1]) : '0);
        end

        // Wrap-around after a core 2 grant
        do_reset();
        set_core(2, 1'b1, 1'b0, 32'h20, '0);
        #1 check("wrap gnt2", core_gnt, 4'b0100);
        @(negedge clk);
        core_req = 4'b1001;
        #1 check("wrap busy gnt", core_gnt, '0);
        @(negedge clk); #1;
        @(negedge clk);
`ifdef MEM_ARB_FIXED_PRIO_EN
        #1 check("wrap first", core_gnt, 4'b0001);
        @(negedge clk); core_req[0] = 1'b0;
`else
        #1 check("wrap first", core_gnt, 4'b1000);
        @(negedge clk); core_req[3] = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
`ifdef MEM_ARB_FIXED_PRIO_EN
        #1 check("wrap second", core_gnt, 4'b1000);
        check("wrap rvalid", core_rvalid, 4'b0001);
`else
        #1 check("wrap second", core_gnt, 4'b0001);
        check("wrap rvalid", core_rvalid, 4'b1000);
`endif

        // Reset during ACCESS
        do_reset();
        set_core(1, 1'b1, 1'b0, 32'h80, '0);
        #1 check("mid gnt", core_gnt, 4'b0010);
        @(negedge clk);
        core_req = '0;
        #1 check("mid mem_req", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst mem_req", mem_req, 1'b0);
        check("mid rst busy",    busy,    1'b0);
        check("mid rst rvalid",  core_rvalid, '0);
        @(negedge clk);
        rst_n = 1'b1;
        core_req = 4'b1010;
        #1 check("mid restart gnt", core_gnt, 4'b0010);
        check("mid rvalid0", core_rvalid, '0);
        @(negedge clk);
        core_req = '0;
        #1 check("mid rvalid1", core_rvalid, '0);
        @(negedge clk); #1 check("mid rvalid2", core_rvalid, '0);

        // Randomized traffic against the timeline model
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < N; c++) begin
                if (granted_w == c) core_req[c] = 1'b0;
                if (!core_req[c]) begin
                    if ($urandom_range(0, 99) < 35)
                        set_core(c, 1'b1, 1'($urandom_range(0, 1)), $urandom & 32'h3FC, $urandom);
                end else if ($urandom_range(0, 99) < 3) begin
                    core_req[c] = 1'b0;
                end
            end
            #1 model_cycle();
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
